math_sweep_checker: RTL
=======================

Name: math_sweep_checker

Overview:
Exhaustive self-test stage wrapped around the combinational 4-bit math block (x2, /2, %2, x4, /4, %4).
- Upstream role: drives the math block's 4-bit operand through 0..15.
- Downstream role: samples the six math results, compares each against internally derived shift/mask expectations, and accumulates error statistics.
- Reports busy/done/pass to board LEDs or the testbench.

Parameters:
SETTLE, 1, cycles each operand is held before its results are sampled; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  sweep request; sampled only while not busy
a_out  output  4  operand driven to math block input a
mul2_in  input  8  math result a*2
div2_in  input  4  math result a/2
mod2_in  input  4  math result a%2
mul4_in  input  8  math result a*4
div4_in  input  4  math result a/4
mod4_in  input  4  math result a%4
busy  output  1  sweep in progress
done  output  1  sweep complete; level, held until next start or reset
pass  output  1  valid when done=1; 1 = zero mismatches
err_cnt  output  5  number of operands with at least one mismatching result (0..16)
err_flags  output  6  sticky per-result mismatch flags; bit0 mul2, bit1 div2, bit2 mod2, bit3 mul4, bit4 div4, bit5 mod4
first_err_a  output  4  operand of the first mismatching vector
first_err_valid  output  1  first_err_a holds a captured value

Behaviour:
- Reset (rst_n=0 at rising edge):
  - State IDLE.
  - a_out, busy, done, pass, err_cnt, err_flags, first_err_a, first_err_valid all 0.
  - Reset overrides start.
  - Reset mid-sweep aborts the sweep at the next edge; done is not asserted.
- States: IDLE, SETTLE, CHECK. A settle counter of width 4 runs inside SETTLE.
- IDLE:
  - start=1 clears done, pass, err_cnt, err_flags, first_err_a and first_err_valid.
  - Same edge: a_out=0, settle counter=0, busy=1, go to SETTLE.
- SETTLE:
  - Hold a_out.
  - Increment the settle counter each cycle.
  - When counter == SETTLE-1, go to CHECK.
- CHECK (exactly one cycle):
  - Expected values, zero-extended to port width:
    - mul2 = {3'b0,a_out,1'b0}
    - div2 = {1'b0,a_out[3:1]}
    - mod2 = {3'b0,a_out[0]}
    - mul4 = {2'b0,a_out,2'b0}
    - div4 = {2'b0,a_out[3:2]}
    - mod4 = {2'b0,a_out[1:0]}
  - Comparison uses full-width equality; any bit difference is a mismatch.
  - err_flags |= per-result mismatch vector.
  - If any mismatch: err_cnt += 1 (max 16, no wrap possible).
  - If any mismatch and first_err_valid=0: first_err_a = a_out, first_err_valid = 1.
  - If a_out != 15: a_out += 1, clear settle counter, go to SETTLE.
  - If a_out == 15:
    - busy=0, done=1, go to IDLE.
    - a_out holds 15.
    - pass = no mismatch so far AND none in this cycle; the last vector is included.
- Latency:
  - Each operand occupies SETTLE+1 cycles.
  - With start sampled at edge E0, done rises at edge E0 + 16*(SETTLE+1).
  - a_out changes only at CHECK edges.
- start while busy=1 is ignored and has no effect on counters.
- start in IDLE with done=1 begins a fresh sweep; done drops at that edge.
- All outputs are registered; no combinational path from any input to any output.
- Mismatch inputs are sampled only in CHECK. Values in SETTLE are don't-care, which absorbs glitches and any future pipelining of the math block.

Test Plan:
1. Correct math model connected, SETTLE=1, 1-cycle start pulse -> a_out steps 0..15, each held 2 cycles; busy high 32 cycles; done=1 at E0+32; pass=1, err_cnt=0, err_flags=0, first_err_valid=0.
2. mod4_in forced to 0 -> mismatches at a in {1,2,3,5,6,7,9,10,11,13,14,15}; err_cnt=12, err_flags=6'b100000, first_err_a=1, first_err_valid=1, pass=0.
3. mul2_in bit4 stuck at 1 -> mismatches at a=0..7; err_cnt=8, err_flags=6'b000001, first_err_a=0, pass=0.
4. start held high for the whole sweep -> exactly one sweep, done at E0+32. After done, a new start pulse -> done drops, err_cnt clears, second sweep completes identically.
5. rst_n=0 for one cycle while a_out=7 -> next edge all outputs 0, state IDLE, done stays 0. A subsequent start runs a full clean sweep.
6. SETTLE=3 with correct model -> each a_out held 4 cycles, done at E0+64, pass=1. Glitching the inputs during SETTLE cycles only -> still pass=1.

Source files
------------

// File: rtl/math_sweep_checker_if.sv
// Operand/result bus between the sweep checker and the combinational 4-bit math block.
// The checker drives the operand and samples the six results.
interface math_sweep_checker_if;
    logic [3:0] a_out;
    logic [7:0] mul2_in;
    logic [3:0] div2_in;
    logic [3:0] mod2_in;
    logic [7:0] mul4_in;
    logic [3:0] div4_in;
    logic [3:0] mod4_in;

    modport master (
        output a_out,
        input  mul2_in, div2_in, mod2_in, mul4_in, div4_in, mod4_in
    );

    modport slave (
        input  a_out,
        output mul2_in, div2_in, mod2_in, mul4_in, div4_in, mod4_in
    );
endinterface

// File: rtl/math_sweep_checker.sv
// Exhaustive self-test of the 4-bit math block: sweeps a = 0..15, checks x2,/2,%2,x4,/4,%4
// against shift/mask expectations and accumulates mismatch statistics.
module math_sweep_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    math_sweep_checker_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [4:0]                  err_cnt,
    output logic [5:0]                  err_flags,
    output logic [3:0]                  first_err_a,
    output logic                        first_err_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] A_LAST      = 4'd15;

    state_e     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] err_cnt_q, err_cnt_d;
    logic [5:0] err_flags_q, err_flags_d;
    logic [3:0] first_err_a_q, first_err_a_d;
    logic       first_err_valid_q, first_err_valid_d;

    logic [7:0] exp_mul2, exp_mul4;
    logic [3:0] exp_div2, exp_mod2, exp_div4, exp_mod4;
    logic [5:0] mismatch;
    logic       any_mismatch;

    // Multiplies/divides by powers of two reduce to wiring, so the expectations are pure shifts and masks.
    always_comb begin
        exp_mul2 = {3'b0, a_q, 1'b0};
        exp_div2 = {1'b0, a_q[3:1]};
        exp_mod2 = {3'b0, a_q[0]};
        exp_mul4 = {2'b0, a_q, 2'b0};
        exp_div4 = {2'b0, a_q[3:2]};
        exp_mod4 = {2'b0, a_q[1:0]};

        mismatch[0]  = (bus.mul2_in != exp_mul2);
        mismatch[1]  = (bus.div2_in != exp_div2);
        mismatch[2]  = (bus.mod2_in != exp_mod2);
        mismatch[3]  = (bus.mul4_in != exp_mul4);
        mismatch[4]  = (bus.div4_in != exp_div4);
        mismatch[5]  = (bus.mod4_in != exp_mod4);
        any_mismatch = |mismatch;
    end

    // NOTE: every next-state variable gets its hold value first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d           = state_q;
        a_d               = a_q;
        cnt_d             = cnt_q;
        busy_d            = busy_q;
        done_d            = done_q;
        pass_d            = pass_q;
        err_cnt_d         = err_cnt_q;
        err_flags_d       = err_flags_q;
        first_err_a_d     = first_err_a_q;
        first_err_valid_d = first_err_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d            = 1'b0;
                    pass_d            = 1'b0;
                    err_cnt_d         = '0;
                    err_flags_d       = '0;
                    first_err_a_d     = '0;
                    first_err_valid_d = 1'b0;
                    a_d               = '0;
                    cnt_d             = '0;
                    busy_d            = 1'b1;
                    state_d           = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                err_flags_d = err_flags_q | mismatch;
                if (any_mismatch) begin
                    err_cnt_d = err_cnt_q + 5'd1;
                    if (!first_err_valid_q) begin
                        first_err_a_d     = a_q;
                        first_err_valid_d = 1'b1;
                    end
                end

                if (a_q != A_LAST) begin
                    a_d     = a_q + 4'd1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    // The last vector counts too, so its mismatch is folded in directly.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_q == 5'd0) && !any_mismatch;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            a_q               <= '0;
            cnt_q             <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_cnt_q         <= '0;
            err_flags_q       <= '0;
            first_err_a_q     <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            a_q               <= a_d;
            cnt_q             <= cnt_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            err_cnt_q         <= err_cnt_d;
            err_flags_q       <= err_flags_d;
            first_err_a_q     <= first_err_a_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign bus.a_out       = a_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign err_flags       = err_flags_q;
    assign first_err_a     = first_err_a_q;
    assign first_err_valid = first_err_valid_q;

endmodule
